reg32_load: RTL and testbench

- 32-bit load-enable holding register with synchronous active-high reset.
- Captures `d` into `q` on a clock edge where `load` is high; otherwise holds its value.
- Per-byte write enables and a first-load valid flag let it serve as a general-purpose datapath/CSR storage element.

---
 rtl/reg32_load_pkg.sv | 14 +
 rtl/reg32_byte_lane.sv | 36 +++
 rtl/reg32_load.sv | 75 +++++++
 tb/tb_reg32_load.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/reg32_load_pkg.sv
// Shared types and helpers for the reg32_load holding register and its byte lanes.
package reg32_load_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int BYTE_W        = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Bit that makes the byte plus itself carry an even number of ones.
    function automatic logic even_parity(input byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/reg32_byte_lane.sv
// One byte of storage with sync reset and write enable; 1-edge latency, never stalls.
// Optional parity bit stored alongside the data when REG32_LOAD_PARITY_EN is defined.
module reg32_byte_lane
    import reg32_load_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  byte_t d,
    input  byte_t rst_val,
    output byte_t q
`ifdef REG32_LOAD_PARITY_EN
    ,
    output logic  par
`endif
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (we) begin
            q <= d;
        end
    end

`ifdef REG32_LOAD_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par <= even_parity(rst_val);
        end else if (we) begin
            par <= even_parity(d);
        end
    end
`endif

endmodule

// File: rtl/reg32_load.sv
// Byte-maskable load-enable holding register with first-load valid flag and load ack pulse.
// Latency one edge, no backpressure; optional par_err output under REG32_LOAD_PARITY_EN.
module reg32_load
    import reg32_load_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH/8-1:0]    byte_en,
    input  logic [WIDTH-1:0]      d,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic                  load_ack
`ifdef REG32_LOAD_PARITY_EN
    ,
    output logic                  par_err
`endif
);

    localparam int NBYTES = WIDTH / BYTE_W;

    logic accepted;

    // A load with an empty mask writes nothing, so it must not count as a load.
    assign accepted = load && (|byte_en);

`ifdef REG32_LOAD_PARITY_EN
    logic [NBYTES-1:0] lane_err;
`endif

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
`ifdef REG32_LOAD_PARITY_EN
        logic lane_par;
`endif
        reg32_byte_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .we      (load & byte_en[i]),
            .d       (d[i*BYTE_W +: BYTE_W]),
            .rst_val (RESET_VAL[i*BYTE_W +: BYTE_W]),
            .q       (q[i*BYTE_W +: BYTE_W])
`ifdef REG32_LOAD_PARITY_EN
            ,
            .par     (lane_par)
`endif
        );
`ifdef REG32_LOAD_PARITY_EN
        assign lane_err[i] = even_parity(q[i*BYTE_W +: BYTE_W]) ^ lane_par;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            q_valid  <= q_valid | accepted;
            load_ack <= accepted;
        end
    end

`ifdef REG32_LOAD_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= |lane_err;
        end
    end
`endif

endmodule

// File: tb/tb_reg32_load.sv
// Scoreboarded bench for reg32_load: directed plan followed by random traffic.
module tb_reg32_load;

    typedef struct {
        logic [31:0] q;
        logic        v;
        logic        ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [3:0]  byte_en = 4'h0;
    logic [31:0] d = 32'h0;
    logic [31:0] q;
    logic        q_valid;
    logic        load_ack;
`ifdef REG32_LOAD_PARITY_EN
    logic        par_err;
`endif

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference state: the register as a whole word plus a sticky valid flag.
    logic [31:0] m_q;
    logic        m_v;

    always #5 clk = ~clk;

    reg32_load #(
        .WIDTH     (32),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .byte_en  (byte_en),
        .d        (d),
        .q        (q),
        .q_valid  (q_valid),
        .load_ack (load_ack)
`ifdef REG32_LOAD_PARITY_EN
        ,
        .par_err  (par_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic issue(input logic r, input logic l, input logic [3:0] be, input logic [31:0] dd);
        exp_t        e;
        logic [31:0] mask;
        logic        acc;
        @(negedge clk);
        rst     = r;
        load    = l;
        byte_en = be;
        d       = dd;
        if (r) begin
            m_q   = 32'h0;
            m_v   = 1'b0;
            e.ack = 1'b0;
        end else begin
            mask = 32'h0;
            for (int i = 0; i < 4; i++)
                if (be[i]) mask = mask | (32'hFF << (8 * i));
            acc = l && (be != 4'h0);
            if (l) m_q = (m_q & ~mask) | (dd & mask);
            if (acc) m_v = 1'b1;
            e.ack = acc;
        end
        e.q = m_q;
        e.v = m_v;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q", q, e.q);
                check("q_valid", {31'h0, q_valid}, {31'h0, e.v});
                check("load_ack", {31'h0, load_ack}, {31'h0, e.ack});
`ifdef REG32_LOAD_PARITY_EN
                check("par_err", {31'h0, par_err}, 32'h0);
`endif
            end
        end
    end

    initial begin : stim
        int drained;
        // Reset wins over a simultaneous load.
        issue(1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 1'b1, 4'hF, 32'd1);
        issue(1'b0, 1'b0, 4'hF, 32'd0);
        issue(1'b0, 1'b1, 4'hF, 32'd0);
        repeat (3) issue(1'b0, 1'b0, 4'hF, 32'd1);
        issue(1'b0, 1'b1, 4'hF, 32'h1122_3344);
        issue(1'b0, 1'b1, 4'b0101, 32'hAABB_CCDD);
        issue(1'b0, 1'b1, 4'b0000, 32'h5555_5555);
        issue(1'b0, 1'b1, 4'hF, 32'd1);
        issue(1'b0, 1'b1, 4'hF, 32'd2);
        issue(1'b0, 1'b1, 4'hF, 32'd3);
        issue(1'b1, 1'b1, 4'hF, 32'd4);
        issue(1'b0, 1'b0, 4'hF, 32'd5);

        for (int n = 0; n < 400; n++) begin
            issue(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom);
        end
        issue(1'b0, 1'b0, 4'h0, 32'h0);

        drained = 0;
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0) begin
                drained = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (drained == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
